seq_multiplier_32bit: RTL and testbench

Multi-cycle unsigned 32x32 shift-add multiplier producing a 64-bit product. It sits directly downstream of the 32-bit bitwise AND stage `my_and_32bit`. Each cycle, that stage gates the multiplicand with the current multiplier LSB to form the partial product. This block registers, accumulates and shifts that partial product over 32 iterations. It provides the MULT path of the ALU datapath, using a start/busy/done handshake to the controller.

---
 rtl/mult_pkg.sv | 16 +
 rtl/seq_multiplier_32bit_if.sv | 21 ++
 rtl/my_and_32bit.sv | 12 +
 rtl/seq_multiplier_32bit.sv | 95 +++++++++
 tb/tb_seq_multiplier_32bit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// operand width and the index of the last iteration.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned CNT_WIDTH  = 5;

    localparam logic [CNT_WIDTH-1:0] MULT_ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/seq_multiplier_32bit_if.sv
// Controller-facing start/busy/done handshake and operand/product bus of the multiplier.
interface seq_multiplier_32bit_if;

    logic                               start;
    logic [mult_pkg::MULT_WIDTH-1:0]    multiplicand;
    logic [mult_pkg::MULT_WIDTH-1:0]    multiplier;
    logic [2*mult_pkg::MULT_WIDTH-1:0]  product;
    logic                               busy;
    logic                               done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done
    );

endinterface : seq_multiplier_32bit_if

// File: rtl/my_and_32bit.sv
// 32-bit bitwise AND stage; gates the multiplicand with the replicated multiplier LSB.
module my_and_32bit
    import mult_pkg::*;
(
    input  logic [MULT_WIDTH-1:0] a,
    input  logic [MULT_WIDTH-1:0] b,
    output logic [MULT_WIDTH-1:0] y_c
);

    assign y_c = a & b;

endmodule : my_and_32bit

// File: rtl/seq_multiplier_32bit.sv
// Unsigned 32x32 shift-add multiplier: one partial product per cycle over 32
// iterations, 64-bit result held in the accumulator until the next accepted start.
module seq_multiplier_32bit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
)
(
    input  logic                   clk,
    input  logic                   reset,
    seq_multiplier_32bit_if.slave  bus
);

    mult_state_t            state;
    mult_state_t            state_next;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mcand_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   busy_reg;
    logic                   done_reg;

    logic [WIDTH-1:0]       hi;
    logic [WIDTH-1:0]       lo;
    logic [WIDTH-1:0]       pp;
    logic [WIDTH:0]         sum_c;

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

    my_and_32bit u_and (
        .a   (mcand),
        .b   ({WIDTH{lo[0]}}),
        .y_c (pp)
    );

    // Carry out of the upper-half add becomes the new MSB after the shift.
    assign sum_c = {1'b0, hi} + {1'b0, pp};

    always_comb begin
        state_next = state;
        acc_next   = acc;
        mcand_next = mcand;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    mcand_next = bus.multiplicand;
                    acc_next   = {WIDTH'(0), bus.multiplier};
                    cnt_next   = '0;
                    state_next = CALC;
                end
            end
            CALC: begin
                acc_next = {sum_c, lo[WIDTH-1:1]};
                cnt_next = cnt + CNT_WIDTH'(1);
                if (cnt == MULT_ITER_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            mcand    <= mcand_next;
            cnt      <= cnt_next;
            busy_reg <= (state_next == CALC);
            done_reg <= (state_next == DONE);
        end
    end

    assign bus.product = acc;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;

endmodule : seq_multiplier_32bit

// File: tb/tb_seq_multiplier_32bit.sv
// Self-checking bench: arithmetic/timing model of the multiplier checked every cycle,
// plus directed vectors with hand-computed products.
module tb_seq_multiplier_32bit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_multiplier_32bit_if bus();

    seq_multiplier_32bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start at edge E0 yields busy after E0..E31, done after E32,
    // idle from E33; the result is the plain 64-bit product of the sampled operands.
    int          edge_n      = 0;
    int          acc_edge    = 0;
    bit          active      = 1'b0;
    bit          model_valid = 1'b0;
    logic [63:0] prod_m      = '0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            active      = 1'b0;
            prod_m      = '0;
            model_valid = 1'b1;
        end else if (!active) begin
            if (bus.start) begin
                active   = 1'b1;
                acc_edge = edge_n;
                prod_m   = 64'(bus.multiplicand) * 64'(bus.multiplier);
            end
        end else if (edge_n == acc_edge + 33) begin
            active = 1'b0;
        end
    end

    bit exp_busy;
    bit exp_done;

    always @(negedge clk) begin
        if (model_valid) begin
            exp_busy = active && (edge_n <= acc_edge + 31);
            exp_done = active && (edge_n == acc_edge + 32);
            check64("busy", 64'(bus.busy), 64'(exp_busy));
            check64("done", 64'(bus.done), 64'(exp_done));
            check64("busy_done_excl", 64'(bus.busy & bus.done), 64'(0));
            if (!active || exp_done) begin
                check64("product_model", bus.product, prod_m);
            end
        end
    end

    task automatic wait_done(input int bound, output int k);
        k = 0;
        while (bus.done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] want, input string name);
        int k;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        wait_done(40, k);
        check_int({name, "_latency"}, k, 32);
        check64(name, bus.product, want);
    endtask

    int  k;
    int  t1;
    bit  seen_done;

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (2) @(negedge clk);
        check64("reset_product", bus.product, 64'h0);
        check64("reset_busy", 64'(bus.busy), 64'h0);
        check64("reset_done", 64'(bus.done), 64'h0);
        reset = 1'b0;

        do_mult(32'd3, 32'd5, 64'h0000_0000_0000_000F, "mul_3x5");
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mul_max");
        do_mult(32'h0, 32'h1234_5678, 64'h0, "mul_zero");
        do_mult(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "mul_msb");
        do_mult(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "mul_2p16");

        // A start pulse mid-operation must not resample the operands.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd100; bus.multiplier = 32'd100;
        @(negedge clk);
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        wait_done(40, k);
        check_int("ignored_start_done_seen", int'(bus.done), 1);
        check64("ignored_start", bus.product, 64'd63);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check64("abort_product", bus.product, 64'h0);
        check64("abort_busy", 64'(bus.busy), 64'h0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        check64("abort_no_done", 64'(seen_done), 64'h0);
        do_mult(32'd2, 32'd2, 64'd4, "mul_after_abort");

        // Continuous start: back-to-back results 34 cycles apart.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd6; bus.multiplier = 32'd7;
        @(negedge clk);
        wait_done(40, k);
        t1 = edge_n;
        check64("cont_first", bus.product, 64'd42);
        @(negedge clk);
        wait_done(40, k);
        bus.start = 1'b0;
        check_int("cont_spacing", edge_n - t1, 34);
        check64("cont_second", bus.product, 64'd42);
        repeat (40) @(negedge clk);
        check64("final_idle_busy", 64'(bus.busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_multiplier_32bit
